wb_stage_pipe: RTL and testbench

//  Parametrised write-back stage: MEM/WB pipeline register, load byte/half/word

---
 rtl/wb_stage_pipe.sv | 146 ++++++++++++++
 tb/tb_wb_stage_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB register, load lane extraction/extension, 4-way result select,
//   r0 write suppression and misaligned-load detection (write killed, flag raised).
// Latency: 1 cycle when PIPE_REG=1, combinational when PIPE_REG=0.
// Backpressure: stall holds every output (a held write simply repeats); flush squashes
//   valid/write/misaligned and overrides stall.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid, stall, flush MEM-stage valid, hold, squash
//   alu_result, read_data, pc_plus4, imm_upper   result sources (read_data little-endian)
//   byte_off, load_size, load_unsigned           load lane/size/extension control
//   wb_sel, reg_write, write_reg                 result select, write enable, destination
//   wb_valid, wb_reg_write, wb_write_reg, wb_write_data, wb_misaligned   WB-stage outputs
module wb_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_REG   = 1,
  parameter int R0_ZERO    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm_upper,
  input  logic [1:0]            byte_off,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            wb_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] write_reg,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0]     wb_write_data,
  output logic                  wb_misaligned
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;
    logic                  misaligned;
  } wb_t;

  // Byte lanes are hard-wired to a 32-bit word.
  generate
    if (DATA_W != 32) begin : g_width_check
      $error("wb_stage_pipe: DATA_W must be 32");
    end
  endgenerate

  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_val;
  logic              bad_align;
  logic              r0_kill;
  wb_t               nxt;
  wb_t               cur;

  always_comb begin
    lane_byte = 8'h00;
    case (byte_off)
      2'd0: lane_byte = read_data[7:0];
      2'd1: lane_byte = read_data[15:8];
      2'd2: lane_byte = read_data[23:16];
      2'd3: lane_byte = read_data[31:24];
      default: lane_byte = 8'h00;
    endcase
  end

  // Odd half offsets land here too, but they are flagged misaligned and zeroed.
  assign lane_half = byte_off[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    load_val  = read_data;
    bad_align = 1'b0;
    case (load_size)
      2'b00: load_val = {{(DATA_W-8){lane_byte[7] & ~load_unsigned}}, lane_byte};
      2'b01: load_val = {{(DATA_W-16){lane_half[15] & ~load_unsigned}}, lane_half};
      default: load_val = read_data;  // reserved size behaves as a word load
    endcase
    // Alignment only matters when the memory result is actually selected.
    if (wb_sel == 2'b01) begin
      case (load_size)
        2'b00:   bad_align = 1'b0;
        2'b01:   bad_align = byte_off[0];
        default: bad_align = (byte_off != 2'b00);
      endcase
    end
  end

  assign r0_kill = (R0_ZERO != 0) && (write_reg == '0);

  always_comb begin
    nxt            = '0;
    nxt.valid      = in_valid;
    nxt.misaligned = in_valid & bad_align;
    nxt.write_reg  = write_reg;
    nxt.reg_write  = in_valid & reg_write & ~bad_align & ~r0_kill;
    case (wb_sel)
      2'b00:   nxt.write_data = alu_result;
      2'b01:   nxt.write_data = bad_align ? '0 : load_val;
      2'b10:   nxt.write_data = pc_plus4;
      default: nxt.write_data = imm_upper;
    endcase
  end

  generate
    if (PIPE_REG != 0) begin : g_reg
      wb_t q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (flush) begin
          // Destination and data are left as-is; only the qualifiers drop.
          q.valid      <= 1'b0;
          q.reg_write  <= 1'b0;
          q.misaligned <= 1'b0;
        end else if (!stall) begin
          q <= nxt;
        end
      end
      assign cur = q;
    end else begin : g_comb
      always_comb begin
        cur = nxt;
        if (flush) begin
          cur.valid      = 1'b0;
          cur.reg_write  = 1'b0;
          cur.misaligned = 1'b0;
        end
      end
    end
  endgenerate

  assign wb_valid      = cur.valid;
  assign wb_reg_write  = cur.reg_write;
  assign wb_write_reg  = cur.write_reg;
  assign wb_write_data = cur.write_data;
  assign wb_misaligned = cur.misaligned;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: a registered instance and a combinational-bypass instance
//   share one set of inputs and are checked against a spec-level reference model.
module tb_wb_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, stall, flush;
  logic [31:0] alu_result, read_data, pc_plus4, imm_upper;
  logic [1:0]  byte_off, load_size, wb_sel;
  logic        load_unsigned, reg_write;
  logic [4:0]  write_reg;

  logic        r_valid, r_we, r_mis, c_valid, c_we, c_mis;
  logic [4:0]  r_wreg, c_wreg;
  logic [31:0] r_data, c_data;

  wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .PIPE_REG(1), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
    .imm_upper(imm_upper), .byte_off(byte_off), .load_size(load_size),
    .load_unsigned(load_unsigned), .wb_sel(wb_sel), .reg_write(reg_write),
    .write_reg(write_reg), .wb_valid(r_valid), .wb_reg_write(r_we),
    .wb_write_reg(r_wreg), .wb_write_data(r_data), .wb_misaligned(r_mis));

  wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .PIPE_REG(0), .R0_ZERO(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
    .imm_upper(imm_upper), .byte_off(byte_off), .load_size(load_size),
    .load_unsigned(load_unsigned), .wb_sel(wb_sel), .reg_write(reg_write),
    .write_reg(write_reg), .wb_valid(c_valid), .wb_reg_write(c_we),
    .wb_write_reg(c_wreg), .wb_write_data(c_data), .wb_misaligned(c_mis));

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        mis;
  } out_t;

  out_t r_out, c_out, exp_q;
  assign r_out = {r_valid, r_we, r_wreg, r_data, r_mis};
  assign c_out = {c_valid, c_we, c_wreg, c_data, c_mis};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got v=%0b we=%0b reg=%0d data=%h mis=%0b, expected v=%0b we=%0b reg=%0d data=%h mis=%0b",
               name, got.valid, got.we, got.wreg, got.data, got.mis,
               want.valid, want.we, want.wreg, want.data, want.mis);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: what the stage should write back for the current inputs,
  // derived from sizes, shifts and masks rather than lane muxes.
  function automatic out_t ref_next();
    out_t        o;
    int          nbytes;
    logic [31:0] sh, mask, val;
    logic        bad;
    nbytes = (load_size == 2'b00) ? 1 : (load_size == 2'b01) ? 2 : 4;
    if (nbytes == 4)      sh = read_data;
    else if (nbytes == 2) sh = read_data >> (16 * int'(byte_off[1]));
    else                  sh = read_data >> (8 * int'(byte_off));
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    val  = sh & mask;
    if (!load_unsigned && nbytes < 4 && (val & ((mask >> 1) + 32'd1)) != 0) val = val | ~mask;
    bad = (wb_sel == 2'b01) && ((int'(byte_off) % nbytes) != 0);
    o.valid = in_valid;
    o.mis   = in_valid && bad;
    o.wreg  = write_reg;
    o.we    = in_valid && reg_write && !bad && (write_reg != 5'd0);
    case (wb_sel)
      2'b00:   o.data = alu_result;
      2'b01:   o.data = bad ? 32'd0 : val;
      2'b10:   o.data = pc_plus4;
      default: o.data = imm_upper;
    endcase
    return o;
  endfunction

  // Inputs must already be set (1 time unit after the previous edge).
  task automatic run_cycle(input string tag);
    out_t nx, cx;
    nx = ref_next();
    cx = nx;
    if (flush) begin cx.valid = 1'b0; cx.we = 1'b0; cx.mis = 1'b0; end
    #1;
    check({tag, "_comb"}, c_out, cx);
    @(posedge clk);
    if (flush) begin
      exp_q.valid = 1'b0; exp_q.we = 1'b0; exp_q.mis = 1'b0;
    end else if (!stall) begin
      exp_q = nx;
    end
    #1;
    check({tag, "_reg"}, r_out, exp_q);
  endtask

  task automatic set_load(input logic [31:0] rd, input logic [1:0] off, input logic [1:0] size,
                          input logic uns, input logic [1:0] sel, input logic rw,
                          input logic [4:0] wr);
    in_valid = 1'b1; read_data = rd; byte_off = off; load_size = size;
    load_unsigned = uns; wb_sel = sel; reg_write = rw; write_reg = wr;
  endtask

  task automatic randomize_inputs();
    alu_result    = $urandom; read_data = $urandom;
    pc_plus4      = $urandom; imm_upper = $urandom;
    byte_off      = 2'($urandom_range(0, 3));
    load_size     = 2'($urandom_range(0, 3));
    load_unsigned = 1'($urandom_range(0, 1));
    wb_sel        = 2'($urandom_range(0, 3));
    reg_write     = ($urandom_range(0, 3) != 0);
    write_reg     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    in_valid      = ($urandom_range(0, 3) != 0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] rd, alu, pc, imm;
    logic [1:0]  off, size, sel;
    logic        uns, rw;
    logic [4:0]  wr;
    logic [31:0] e_data;
    logic        e_we, e_mis;
  } vec_t;

  vec_t vecs[$];
  out_t snap;

  initial begin
    vecs.push_back('{"lb_off3",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd3, 2'b00, 2'b01, 1'b0, 1'b1, 5'd3,  32'hFFFF_FF80, 1'b1, 1'b0});
    vecs.push_back('{"lbu_off3",  32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd3, 2'b00, 2'b01, 1'b1, 1'b1, 5'd3,  32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{"lh_off2",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd2, 2'b01, 2'b01, 1'b0, 1'b1, 5'd4,  32'hFFFF_80FF, 1'b1, 1'b0});
    vecs.push_back('{"lhu_off0",  32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd0, 2'b01, 2'b01, 1'b1, 1'b1, 5'd4,  32'h0000_7F01, 1'b1, 1'b0});
    vecs.push_back('{"lw",        32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd0, 2'b10, 2'b01, 1'b0, 1'b1, 5'd5,  32'h80FF_7F01, 1'b1, 1'b0});
    vecs.push_back('{"lh_off1",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd1, 2'b01, 2'b01, 1'b0, 1'b1, 5'd6,  32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"lb_off1",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd1, 2'b00, 2'b01, 1'b0, 1'b1, 5'd6,  32'h0000_007F, 1'b1, 1'b0});
    vecs.push_back('{"lw_off2",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd2, 2'b10, 2'b01, 1'b0, 1'b1, 5'd7,  32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{"link_r31",  32'h0, 32'h0, 32'h0000_0048, 32'h0, 2'd0, 2'b00, 2'b10, 1'b0, 1'b1, 5'd31, 32'h0000_0048, 1'b1, 1'b0});
    vecs.push_back('{"link_r0",   32'h0, 32'h0, 32'h0000_0048, 32'h0, 2'd0, 2'b00, 2'b10, 1'b0, 1'b1, 5'd0,  32'h0000_0048, 1'b0, 1'b0});
    vecs.push_back('{"lui",       32'h0, 32'h0, 32'h0, 32'h1234_0000, 2'd0, 2'b00, 2'b11, 1'b0, 1'b1, 5'd8,  32'h1234_0000, 1'b1, 1'b0});
    vecs.push_back('{"alu_ign",   32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'd3, 2'b10, 2'b00, 1'b0, 1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{"lsz3_word", 32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd0, 2'b11, 2'b01, 1'b1, 1'b1, 5'd10, 32'h80FF_7F01, 1'b1, 1'b0});
    vecs.push_back('{"lh_norw",   32'h80FF_7F01, 32'h0, 32'h0, 32'h0, 2'd2, 2'b01, 2'b01, 1'b0, 1'b0, 5'd11, 32'hFFFF_80FF, 1'b0, 1'b0});

    // Reset state
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_result = '0; read_data = '0; pc_plus4 = '0; imm_upper = '0;
    byte_off = '0; load_size = '0; load_unsigned = 1'b0; wb_sel = '0;
    reg_write = 1'b0; write_reg = '0;
    exp_q = '0;
    @(posedge clk); #1;
    check("reset_state", r_out, '0);
    reset = 1'b0;

    // Table vectors, registered and combinational views
    foreach (vecs[i]) begin
      set_load(vecs[i].rd, vecs[i].off, vecs[i].size, vecs[i].uns, vecs[i].sel, vecs[i].rw, vecs[i].wr);
      alu_result = vecs[i].alu; pc_plus4 = vecs[i].pc; imm_upper = vecs[i].imm;
      #1;
      check32({vecs[i].name, "_comb_data"}, c_data, vecs[i].e_data);
      run_cycle(vecs[i].name);
      check32({vecs[i].name, "_data"}, r_data, vecs[i].e_data);
      check32({vecs[i].name, "_we_mis_v"}, {29'd0, r_we, r_mis, r_valid}, {29'd0, vecs[i].e_we, vecs[i].e_mis, 1'b1});
    end

    // Stall for three cycles with inputs changing: outputs frozen
    set_load(32'hCAFE_F00D, 2'd0, 2'b10, 1'b0, 2'b01, 1'b1, 5'd12);
    run_cycle("pre_stall");
    snap = '{valid: 1'b1, we: 1'b1, wreg: 5'd12, data: 32'hCAFE_F00D, mis: 1'b0};
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      randomize_inputs();
      run_cycle("stall");
      check("stall_frozen", r_out, snap);
    end
    // Flush and stall together: qualifiers drop, destination/data retained
    flush = 1'b1; stall = 1'b1;
    run_cycle("flush_stall");
    snap.valid = 1'b0; snap.we = 1'b0;
    check("flush_stall_const", r_out, snap);
    flush = 1'b0; stall = 1'b0;

    // Asynchronous reset while stalled, then first load one cycle after release
    set_load(32'h1357_9BDF, 2'd0, 2'b10, 1'b0, 2'b01, 1'b1, 5'd13);
    run_cycle("pre_reset");
    stall = 1'b1;
    randomize_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", r_out, '0);
    exp_q = '0;
    @(posedge clk); #1;
    check("reset_held", r_out, '0);
    reset = 1'b0; stall = 1'b0;
    set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b1, 2'b01, 1'b1, 5'd14);
    #1;
    check("post_reset_before_edge", r_out, '0);
    run_cycle("post_reset_load");
    check32("post_reset_data", r_data, 32'h0000_0080);

    // Randomized traffic including stalls, flushes and bubbles
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
